// File: rtl/data_memory_sized.sv
// Byte/half/word data memory with programmable wait states and a req/busy/done handshake.
// Misaligned, out-of-range and invalid-size accesses complete with error instead of touching the array.
`timescale 1ns/1ps
module data_memory_sized #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           dataIn,
  output logic [31:0]           dataOut,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [1:0]            state;
  logic [3:0]            cnt;
  logic                  we_q, sx_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           din_q;

  logic                  accept, go_done, bad;
  logic                  op_we, op_sx;
  logic [1:0]            op_size;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [31:0]           op_din;
  logic [ADDR_WIDTH-3:0] idx;
  logic [AW-1:0]         midx;
  logic [31:0]           rd_word, shifted, load_val, wdata, merged;
  logic [3:0]            lanes;

  assign accept  = (state == S_IDLE) && req;
  assign go_done = (accept && (WAIT_CYCLES == 0)) || ((state == S_WAIT) && (cnt == 4'd1));

  // With zero wait states the access completes on the accept edge, so operands come straight from the ports.
  always_comb begin
    op_we   = we_q;
    op_sx   = sx_q;
    op_size = size_q;
    op_addr = addr_q;
    op_din  = din_q;
    if (state == S_IDLE) begin
      op_we   = we;
      op_sx   = sign_ext;
      op_size = size;
      op_addr = address;
      op_din  = dataIn;
    end
  end

  assign idx     = op_addr[ADDR_WIDTH-1:2];
  assign midx    = idx[AW-1:0];
  assign rd_word = mem[midx];
  assign shifted = rd_word >> {op_addr[1:0], 3'b000};

  always_comb begin
    bad = (64'(idx) >= 64'(DEPTH_WORDS));
    case (op_size)
      2'b00:   bad = bad;
      2'b01:   bad = bad | op_addr[0];
      2'b10:   bad = bad | (op_addr[1:0] != 2'b00);
      default: bad = 1'b1;
    endcase
  end

  always_comb begin
    load_val = shifted;
    lanes    = 4'b1111;
    wdata    = op_din;
    case (op_size)
      2'b00: begin
        load_val = {{24{op_sx & shifted[7]}}, shifted[7:0]};
        lanes    = 4'b0001 << op_addr[1:0];
        wdata    = {4{op_din[7:0]}};
      end
      2'b01: begin
        load_val = {{16{op_sx & shifted[15]}}, shifted[15:0]};
        lanes    = 4'b0011 << op_addr[1:0];
        wdata    = {2{op_din[15:0]}};
      end
      default: ;
    endcase
    merged = rd_word;
    for (int unsigned i = 0; i < 4; i++)
      if (lanes[i]) merged[8*i +: 8] = wdata[8*i +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      sx_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dataOut <= '0;
      error   <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        S_IDLE: if (req) begin
          we_q   <= we;
          sx_q   <= sign_ext;
          size_q <= size;
          addr_q <= address;
          din_q  <= dataIn;
          cnt    <= 4'(WAIT_CYCLES);
          state  <= (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
      if (go_done) begin
        error <= bad;
        if (bad)        dataOut <= '0;
        else if (!op_we) dataOut <= load_val;
      end
    end
  end

  // Gated by rst_n so a reset coinciding with completion drops the store.
  always_ff @(posedge clk) begin
    if (go_done && rst_n && op_we && !bad)
      mem[midx] <= merged;
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);
endmodule

// File: tb/tb_data_memory_sized.sv
// Randomized bench for data_memory_sized: two instances (0 and 3 wait states) checked
// against a byte-array reference model.
`timescale 1ns/1ps
module tb_data_memory_sized;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        we [2];
  logic        sx [2];
  logic [1:0]  size [2];
  logic [31:0] address [2];
  logic [31:0] dataIn [2];
  logic [31:0] dataOut [2];
  logic        busy [2];
  logic        done [2];
  logic        error [2];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mb [2][1024];
  logic [31:0] exp_dout [2];
  int          wc [2] = '{0, 3};

  always #5 clk = ~clk;

  data_memory_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .size(size[0]),
    .sign_ext(sx[0]), .address(address[0]), .dataIn(dataIn[0]),
    .dataOut(dataOut[0]), .busy(busy[0]), .done(done[0]), .error(error[0]));

  data_memory_sized #(.ADDR_WIDTH(32), .DEPTH_WORDS(256), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .size(size[1]),
    .sign_ext(sx[1]), .address(address[1]), .dataIn(dataIn[1]),
    .dataOut(dataOut[1]), .busy(busy[1]), .done(done[1]), .error(error[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || ((a >> 2) >= 256);
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [1:0] sz, input bit s, input logic [31:0] a);
    int n = 1 << sz;
    longint v = 0;
    for (int i = 0; i < n; i++) v = v | (longint'(mb[d][a + i]) << (8 * i));
    if (s && v[8 * n - 1]) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic do_access(input int d, input bit w, input logic [1:0] sz, input bit s,
                           input logic [31:0] a, input logic [31:0] din, input string tag);
    int k;
    bit e;
    @(negedge clk);
    req[d] = 1'b1; we[d] = w; size[d] = sz; sx[d] = s; address[d] = a; dataIn[d] = din;
    @(posedge clk); #1;
    req[d] = 1'b0; we[d] = $urandom; size[d] = 2'($urandom);
    address[d] = $urandom; dataIn[d] = $urandom; sx[d] = $urandom;
    k = 0;
    while (!done[d] && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "/latency"}, k, wc[d]);
    check({tag, "/busy"}, 32'(busy[d]), 32'd1);
    e = m_err(sz, a);
    check({tag, "/error"}, 32'(error[d]), 32'(e));
    if (e) exp_dout[d] = '0;
    else if (!w) exp_dout[d] = m_load(d, sz, s, a);
    else for (int i = 0; i < (1 << sz); i++) mb[d][a + i] = din[8 * i +: 8];
    check({tag, "/dataOut"}, dataOut[d], exp_dout[d]);
    @(posedge clk); #1;
    check({tag, "/idle"}, {30'd0, busy[d], done[d]}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; sx[d] = 0; size[d] = 0; address[d] = 0; dataIn[d] = 0;
      exp_dout[d] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      check($sformatf("reset%0d", d), {dataOut[d] | {29'd0, busy[d], done[d], error[d]}}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Known contents for the random window (words 0..15) on both instances.
    for (int wi = 0; wi < 16; wi++)
      for (int d = 0; d < 2; d++)
        do_access(d, 1, 2'd2, 0, 32'(wi * 4), $urandom, "init");

    do_access(0, 1, 2'd2, 0, 32'd400, 32'hF00FF176, "t1_st");
    do_access(0, 0, 2'd2, 0, 32'd400, 32'h0, "t1_ld");
    check("t1_value", dataOut[0], 32'hF00FF176);
    do_access(0, 1, 2'd0, 0, 32'd401, 32'h000000AB, "t2_stb");
    do_access(0, 0, 2'd2, 0, 32'd400, 32'h0, "t2_ldw");
    check("t2_merge", dataOut[0], 32'hF00FAB76);
    do_access(0, 0, 2'd0, 1, 32'd401, 32'h0, "t2_lbs");
    check("t2_sext", dataOut[0], 32'hFFFFFFAB);
    do_access(0, 0, 2'd0, 0, 32'd401, 32'h0, "t2_lbu");
    do_access(0, 0, 2'd1, 1, 32'd402, 32'h0, "t3_lhs");
    check("t3_half", dataOut[0], 32'hFFFFF00F);
    do_access(0, 0, 2'd1, 1, 32'd401, 32'h0, "t3_mis_h");
    do_access(0, 1, 2'd2, 0, 32'd402, 32'h11111111, "t3_mis_w");
    do_access(0, 0, 2'd2, 0, 32'd400, 32'h0, "t3_keep");
    do_access(0, 0, 2'd2, 0, 32'h400, 32'h0, "t5_range");
    do_access(0, 0, 2'd3, 0, 32'd4, 32'h0, "t5_size");

    // Continuous req on the 3-wait instance: accept period is 5 edges.
    @(negedge clk);
    req[1] = 1; we[1] = 0; size[1] = 2'd2; sx[1] = 0; address[1] = 32'd0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4_busy%0d", k), 32'(busy[1]), 32'((k % 5) <= 3));
      check($sformatf("t4_done%0d", k), 32'(done[1]), 32'((k % 5) == 3));
    end
    req[1] = 0;
    for (int k = 0; k < 10 && busy[1]; k++) begin @(posedge clk); #1; end
    exp_dout[1] = m_load(1, 2'd2, 0, 32'd0);
    check("t4_data", dataOut[1], exp_dout[1]);
    check("t4_idle", 32'(busy[1]), 32'd0);

    // Reset during the wait phase must drop the pending store.
    @(negedge clk);
    req[1] = 1; we[1] = 1; size[1] = 2'd2; address[1] = 32'd8; dataIn[1] = 32'h12345678;
    @(posedge clk); #1;
    req[1] = 0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("t6_rst%0d", d), {dataOut[d] | {29'd0, busy[d], done[d], error[d]}}, 32'd0);
      exp_dout[d] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_access(1, 0, 2'd2, 0, 32'd8, 32'h0, "t6_old");

    for (int it = 0; it < 80; it++) begin
      int d;
      logic [31:0] a;
      d = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) a = 32'((256 + $urandom_range(0, 50)) * 4 + $urandom_range(0, 3));
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_access(d, 1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
